// File: rtl/elevator_car_if.sv
// Command/status bundle between the elevator controller (master) and the car/door plant (slave).
interface elevator_car_if #(
  parameter int unsigned FLOOR_W = 3
);
  logic               cmd_up;
  logic               cmd_down;
  logic               cmd_open;
  logic               fault_clr;
  logic               ready_o;
  logic [FLOOR_W-1:0] floor_o;
  logic [1:0]         dir_o;
  logic               arrive_o;
  logic               door_open_o;
  logic               door_busy_o;
  logic               door_done_o;
  logic               fault_o;

  modport master (
    output cmd_up, cmd_down, cmd_open, fault_clr,
    input  ready_o, floor_o, dir_o, arrive_o, door_open_o, door_busy_o, door_done_o, fault_o
  );

  modport slave (
    input  cmd_up, cmd_down, cmd_open, fault_clr,
    output ready_o, floor_o, dir_o, arrive_o, door_open_o, door_busy_o, door_done_o, fault_o
  );
endinterface

// File: rtl/elevator_car.sv
// Car/door plant: moves one floor per accepted up/down command and sequences the door
// open/hold/close cycle, reporting floor, direction, arrival, door status and faults.
module elevator_car #(
  parameter int unsigned FLOORS        = 8,
  parameter int unsigned FLOOR_W       = 3,
  parameter int unsigned TRAVEL_CYC    = 100,
  parameter int unsigned DOOR_MOVE_CYC = 20,
  parameter int unsigned DOOR_CYC      = 200
) (
  input  logic          clk,
  input  logic          rst,
  elevator_car_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    MOVE,
    D_OPENING,
    D_OPEN,
    D_CLOSING
  } state_t;

  localparam int unsigned CMAX_A = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
  localparam int unsigned CMAX   = (CMAX_A > DOOR_MOVE_CYC) ? CMAX_A : DOOR_MOVE_CYC;
  localparam int unsigned CW     = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0]      TRAVEL_LD = CW'(TRAVEL_CYC - 1);
  localparam logic [CW-1:0]      DMOVE_LD  = CW'(DOOR_MOVE_CYC - 1);
  localparam logic [CW-1:0]      HOLD_LD   = CW'(DOOR_CYC - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(FLOORS - 1);

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [FLOOR_W-1:0] floor_q, floor_d;
  logic               up_q, up_d;
  logic               arrive_q, arrive_d;
  logic               done_q, done_d;
  logic               fault_q, fault_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      floor_q  <= '0;
      up_q     <= 1'b0;
      arrive_q <= 1'b0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      floor_q  <= floor_d;
      up_q     <= up_d;
      arrive_q <= arrive_d;
      done_q   <= done_d;
      // a new illegal command outranks a simultaneous clear
      if (fault_set)         fault_q <= 1'b1;
      else if (bus.fault_clr) fault_q <= 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    floor_d   = floor_q;
    up_d      = up_q;
    arrive_d  = 1'b0;
    done_d    = 1'b0;
    fault_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_up && bus.cmd_down) begin
          fault_set = 1'b1;
        end else if (bus.cmd_open) begin
          state_d = D_OPENING;
          cnt_d   = DMOVE_LD;
        end else if (bus.cmd_up) begin
          if (floor_q == TOP_FLOOR) begin
            fault_set = 1'b1;
          end else begin
            state_d = MOVE;
            up_d    = 1'b1;
            cnt_d   = TRAVEL_LD;
          end
        end else if (bus.cmd_down) begin
          if (floor_q == '0) begin
            fault_set = 1'b1;
          end else begin
            state_d = MOVE;
            up_d    = 1'b0;
            cnt_d   = TRAVEL_LD;
          end
        end
      end
      MOVE: begin
        if (cnt_q == '0) begin
          state_d  = IDLE;
          floor_d  = up_q ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
          arrive_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      D_OPENING: begin
        if (cnt_q == '0) begin
          state_d = D_OPEN;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      D_OPEN: begin
        if (bus.cmd_open) begin
          cnt_d = HOLD_LD;
        end else if (cnt_q == '0) begin
          state_d = D_CLOSING;
          cnt_d   = DMOVE_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      D_CLOSING: begin
        if (bus.cmd_open) begin
          state_d = D_OPENING;
          cnt_d   = DMOVE_LD;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ready_o     = (state_q == IDLE);
  assign bus.floor_o     = floor_q;
  assign bus.dir_o       = (state_q == MOVE) ? (up_q ? 2'd2 : 2'd1) : 2'd0;
  assign bus.arrive_o    = arrive_q;
  assign bus.door_open_o = (state_q == D_OPEN);
  assign bus.door_busy_o = (state_q == D_OPENING) || (state_q == D_OPEN) || (state_q == D_CLOSING);
  assign bus.door_done_o = done_q;
  assign bus.fault_o     = fault_q;

endmodule
